// File: rtl/cdb_pkg.sv
// cdb_pkg: shared Common Data Bus definitions.
// Holds the default CDB field widths and the broadcast record that the ROB
// and reservation stations reuse when snooping the bus.
package cdb_pkg;

   // Default CDB field widths (result value width and ROB tag width).
   localparam int CDB_XLEN  = 32;
   localparam int CDB_TAG_W = 5;

   // One CDB broadcast: valid qualifier, ROB tag and result value.
   typedef struct packed {
      logic                 valid;
      logic [CDB_TAG_W-1:0] tag;
      logic [CDB_XLEN-1:0]  value;
   } cdb_t;

   // Modulo-n increment with an explicit compare, so n need not be a power of two.
   function automatic int wrap_inc(input int k, input int n);
      return (k == n - 1) ? 0 : k + 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational one-hot grant from a request vector.
// With CDB_ROUND_ROBIN_EN defined, the scan starts at ptr and wraps modulo N.
// Without it, the lowest set request bit wins and there is no ptr port.
module rr_arbiter
   import cdb_pkg::*;
#(
   parameter int N = 3
) (
   input  logic [N-1:0]         req,
`ifdef CDB_ROUND_ROBIN_EN
   input  logic [$clog2(N)-1:0] ptr,
`endif
   output logic [N-1:0]         grant
);

`ifdef CDB_ROUND_ROBIN_EN
   // Scan ptr, ptr+1, ... (mod N) and grant the first requester found.
   always_comb begin
      int   idx;
      logic found;
      grant = '0;
      found = 1'b0;
      idx   = int'(ptr);
      for (int i = 0; i < N; i++) begin
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
         idx = wrap_inc(idx, N);
      end
   end
`else
   // Fixed priority: the lowest-index requester wins.
   always_comb begin
      logic found;
      grant = '0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!found && req[i]) begin
            grant[i] = 1'b1;
            found    = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: Common Data Bus arbiter. Picks at most one completed result per
// cycle from NUM_SRC functional-unit FIFOs, pops it via grant_o and broadcasts
// it from a register one cycle later.
// Macro CDB_ROUND_ROBIN_EN: defined -> round-robin selection with a rotating
// priority pointer; undefined -> fixed priority (lowest index wins, no pointer).
module cdb_arbiter
   import cdb_pkg::*;
#(
   parameter int NUM_SRC = 3,
   parameter int XLEN    = CDB_XLEN,
   parameter int TAG_W   = CDB_TAG_W
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            stall_i,
   input  logic                            flush_i,
   input  logic [NUM_SRC-1:0]              req_i,
   input  logic [NUM_SRC-1:0][TAG_W-1:0]   tag_i,
   input  logic [NUM_SRC-1:0][XLEN-1:0]    value_i,
   output logic [NUM_SRC-1:0]              grant_o,
   output logic                            cdb_valid_o,
   output logic [TAG_W-1:0]                cdb_tag_o,
   output logic [XLEN-1:0]                 cdb_value_o
);

   // Requests are masked while in reset, stalled or flushing, so grant_o
   // (the FIFO pop strobe) can only fire when the CDB register will load.
   logic [NUM_SRC-1:0] arb_req;
   logic [TAG_W-1:0]   sel_tag;
   logic [XLEN-1:0]    sel_value;

   assign arb_req = (rst && !stall_i && !flush_i) ? req_i : '0;

`ifdef CDB_ROUND_ROBIN_EN
   localparam int PTR_W = $clog2(NUM_SRC);
   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] ptr_next;

   // Next pointer is one past the granted source, wrapping by compare.
   always_comb begin
      ptr_next = ptr;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (grant_o[k]) ptr_next = PTR_W'(wrap_inc(k, NUM_SRC));
      end
   end
`endif

   rr_arbiter #(.N(NUM_SRC)) u_arb (
      .req   (arb_req),
`ifdef CDB_ROUND_ROBIN_EN
      .ptr   (ptr),
`endif
      .grant (grant_o)
   );

   // Mux the granted source's head-of-FIFO tag and value onto the capture path.
   always_comb begin
      sel_tag   = '0;
      sel_value = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (grant_o[k]) begin
            sel_tag   = tag_i[k];
            sel_value = value_i[k];
         end
      end
   end

   // CDB register: flush clears valid, stall freezes everything, otherwise
   // valid follows the grant and tag/value load only on a grant.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cdb_valid_o <= 1'b0;
         cdb_tag_o   <= '0;
         cdb_value_o <= '0;
`ifdef CDB_ROUND_ROBIN_EN
         ptr         <= '0;
`endif
      end else if (flush_i) begin
         cdb_valid_o <= 1'b0;
      end else if (!stall_i) begin
         if (|grant_o) begin
            cdb_valid_o <= 1'b1;
            cdb_tag_o   <= sel_tag;
            cdb_value_o <= sel_value;
`ifdef CDB_ROUND_ROBIN_EN
            ptr         <= ptr_next;
`endif
         end else begin
            cdb_valid_o <= 1'b0;
         end
      end
   end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common Data Bus arbiter that sits directly downstream of the functional-unit reservation stations (rs_alu and its siblings). Each cycle it selects at most one completed result (tag, value) from the output FIFOs of NUM_SRC units. It pops the selected FIFO via its cdb_en and broadcasts the result, registered, to the ROB and all reservation stations. Selection is round-robin so that no unit starves.

## Interface
Parameters:
- NUM_SRC, 3, number of functional-unit result sources (2..8)
- XLEN, `XLEN, result value width
- TAG_W, `ROB_SIZE, ROB tag width

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- stall_i  in  1  global stall; freezes arbiter and CDB register
- flush_i  in  1  synchronous squash (branch mispredict)
- req_i  in  NUM_SRC  source k has a result; driven by !fifo_empty of unit k
- tag_i  in  NUM_SRC x TAG_W  head-of-FIFO tag per source
- value_i  in  NUM_SRC x XLEN  head-of-FIFO value per source
- grant_o  out  NUM_SRC  one-hot pop strobe; wired to cdb_en of unit k
- cdb_valid_o  out  1  broadcast valid
- cdb_tag_o  out  TAG_W  broadcast ROB tag
- cdb_value_o  out  XLEN  broadcast value

## Operation
- State: priority pointer ptr (0..NUM_SRC-1); CDB register {valid, tag, value}.
- Reset (rst=0, asynchronous): ptr=0, cdb_valid_o=0, cdb_tag_o=0, cdb_value_o=0. grant_o is forced to 0 while rst=0.
- Grant (combinational): if stall_i=0, flush_i=0 and req_i≠0, grant_o is one-hot on the first set req_i bit scanning ptr, ptr+1, … modulo NUM_SRC. Otherwise grant_o=0.
- Capture at the clock edge:
  - grant to k: valid←1, tag←tag_i[k], value←value_i[k], ptr←(k+1) mod NUM_SRC.
  - No grant, with stall_i=0 and flush_i=0: valid←0; tag and value hold; ptr holds.
  - stall_i=1 and flush_i=0: all state holds, including valid.
  - flush_i=1: valid←0; ptr holds. flush_i overrides stall_i.
- A source is popped exactly once per grant cycle. A req_i bit that drops without being granted is ignored, with no memory of it.
- Width rules: the ptr wrap uses explicit compare, not a power-of-two mask. Tag and value pass through unmodified.

## Timing
- Grant-to-broadcast latency is 1 cycle. The result at the FIFO head in cycle t appears on the CDB in cycle t+1.
- Throughput is one broadcast per cycle. All sources requesting continuously are served k, k+1, … in strict rotation.
- The FIFO pop occurs at the same edge that loads the CDB register, so the next head is visible in cycle t+1.
- cdb_valid_o is a single-cycle pulse per result unless stall_i holds it.
- Reset released mid-stream: the first grant occurs in the first cycle with rst=1. No stale broadcast occurs.

## Configuration
- CDB_ROUND_ROBIN_EN defined: round-robin arbitration as above.
- CDB_ROUND_ROBIN_EN undefined: fixed priority, where the lowest index wins. ptr is removed, and everything else is identical.

## Structure
- The CDB width constants (TAG_W and XLEN defaults) come from constants.vh.
- Shared package cdb_pkg holds typedef cdb_t packed {valid, tag, value}. The ROB and reservation stations reuse it for snooping.
- Sub-module rr_arbiter (parameter N) is a combinational one-hot grant from req and ptr. It has a fixed-priority variant under the macro.

## Test plan
- Reset: hold rst=0 with req_i=3'b111. Required: grant_o=0 and cdb_valid_o=0. After release, the first grant is to source 0.
- Single source: req_i=3'b001, tag 12, value 48 (16+32) for one cycle. Required: grant_o=001 that cycle; next cycle cdb_valid_o=1, tag 12, value 48; the cycle after, valid=0.
- Fairness: req_i=3'b111 held for 6 cycles with distinct tags 1/2/3. Required: grants 001,010,100,001,010,100; CDB tags 1,2,3,1,2,3 each one cycle later. With the macro undefined, the grant is 001 every cycle.
- Wrap: ptr=2 (after granting source 1), req_i=3'b011. Required: grant to 0, then ptr=1.
- Stall: stall_i=1 for 3 cycles while valid=1, tag 5. Required: grant_o=0 and the CDB holds tag 5 with valid=1. On release, arbitration resumes from the held ptr.
- Flush: flush_i=1 coincident with req_i=3'b100 and stall_i=1. Required: no grant; next cycle cdb_valid_o=0; ptr unchanged.
